fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register of the pipelined MIPS core.
- Holds the PC, drives the instruction-memory address, captures fetched instructions into the decode stage, and applies branch/jump redirects resolved in D.
- Consumes stallF/stallD from the hazard unit. Feeds instrD/pcplus4D to decode, register-file read and branch-compare logic.

---
 rtl/fetch_stage_if.sv | 20 ++
 rtl/fetch_stage.sv | 95 +++++++++
 tb/tb_fetch_stage.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and the memory (slave).
// The read is combinational: imem_rdata follows imem_addr in the same cycle,
// and imem_ready says whether that word is valid this cycle.
interface fetch_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output imem_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register of the pipelined MIPS core.
// Holds the PC, drives the instruction-memory address, captures fetched words
// into decode and applies branch/jump redirects resolved in D. A redirect that
// arrives while the PC is stalled is parked and applied once the stall lifts.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,            // synchronous, active-low
  input  logic               stallF,
  input  logic               stallD,
  input  logic               pcsrcD,
  input  logic [31:0]        pcbranchD,
  input  logic               jumpD,
  fetch_stage_if.master      imem,
  output logic [31:0]        instrD,
  output logic [31:0]        pcplus4D,
  output logic               validD,
  output logic               redirect_pending
);

  logic [31:0] pcF;
  logic [31:0] pcPlus4F;
  logic [31:0] pendTarget;
  logic [31:0] jumpTarget;
  logic [31:0] redirTarget;
  logic        redir;

  // The memory address is the PC register itself; no logic in between.
  assign imem.imem_addr = pcF;

  // Sequential PC; 0xFFFF_FFFC naturally wraps to 0.
  assign pcPlus4F = pcF + 32'd4;

  // Pseudo-direct jump target from the instruction sitting in D.
  assign jumpTarget = {pcplus4D[31:28], instrD[25:0], 2'b00};

  // Branch/jump requests only count for a real instruction whose operands are
  // resolved (D not stalled). Jump wins if both are asserted.
  assign redir       = validD & ~stallD & (jumpD | pcsrcD);
  assign redirTarget = jumpD ? jumpTarget : pcbranchD;

  // PC and parked-redirect state: stall, redirect, pending, advance, wait.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge only, so it lives inside the
    // clocked branch and overrides every other condition, including a stall.
    if (!reset) begin
      // NOTE: non-blocking assignments keep all registers updating from the
      // same pre-edge values regardless of statement order.
      pcF              <= RESET_PC;
      redirect_pending <= 1'b0;
      pendTarget       <= 32'h0000_0000;
    end else if (stallF) begin
      // PC frozen; remember the most recent redirect so it is not lost.
      if (redir) begin
        redirect_pending <= 1'b1;
        pendTarget       <= redirTarget;
      end
    end else if (redir) begin
      pcF              <= redirTarget;
      redirect_pending <= 1'b0;
    end else if (redirect_pending) begin
      pcF              <= pendTarget;
      redirect_pending <= 1'b0;
    end else if (imem.imem_ready) begin
      pcF <= pcPlus4F;
    end
  end

  // IF/ID register: hold on stallD, flush on redirect, bubble when nothing
  // valid is being fetched, otherwise capture the fetched word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      instrD   <= NOP_INSTR;
      pcplus4D <= 32'h0000_0000;
      validD   <= 1'b0;
    end else if (stallD) begin
      instrD   <= instrD;
      pcplus4D <= pcplus4D;
      validD   <= validD;
    end else if (redir || stallF || redirect_pending || !imem.imem_ready) begin
      // The word in F is either wrong-path, not yet valid, or will be
      // refetched after the stall, so D receives a bubble.
      instrD   <= NOP_INSTR;
      pcplus4D <= 32'h0000_0000;
      validD   <= 1'b0;
    end else begin
      instrD   <= imem.imem_rdata;
      pcplus4D <= pcPlus4F;
      validD   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage. Each vector holds the inputs
// applied for one clock cycle and the register values expected right after
// that edge. The instruction memory is a small combinational model.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stallF;
  logic        stallD;
  logic        pcsrcD;
  logic [31:0] pcbranchD;
  logic        jumpD;
  logic [31:0] instrD;
  logic [31:0] pcplus4D;
  logic        validD;
  logic        redirect_pending;

  int checks   = 0;
  int failures = 0;

  fetch_stage_if bus ();

  fetch_stage dut (
    .clk              (clk),
    .reset            (reset),
    .stallF           (stallF),
    .stallD           (stallD),
    .pcsrcD           (pcsrcD),
    .pcbranchD        (pcbranchD),
    .jumpD            (jumpD),
    .imem             (bus.master),
    .instrD           (instrD),
    .pcplus4D         (pcplus4D),
    .validD           (validD),
    .redirect_pending (redirect_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Address-tagged memory with two jump instructions planted:
  // 0x100: j 0x40  (0x0800_0010), 0x44: j 0x100 (0x0800_0040).
  function automatic logic [31:0] memWord(input logic [31:0] a);
    case (a)
      32'h0000_0100: memWord = 32'h0800_0010;
      32'h0000_0044: memWord = 32'h0800_0040;
      default:       memWord = 32'hC000_0000 | a;
    endcase
  endfunction

  assign bus.imem_rdata = memWord(bus.imem_addr);

  typedef struct {
    logic        rst;
    logic        stF;
    logic        stD;
    logic        pcsrc;
    logic        jump;
    logic [31:0] pcbr;
    logic        rdy;
    logic [31:0] expAddr;
    logic [31:0] expInstr;
    logic [31:0] expP4;
    logic        expValid;
    logic        expPend;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic rst, input logic stF, input logic stD,
                        input logic pcsrc, input logic jump, input logic [31:0] pcbr,
                        input logic rdy, input logic [31:0] expAddr,
                        input logic [31:0] expInstr, input logic [31:0] expP4,
                        input logic expValid, input logic expPend);
    vec_t v;
    v.rst = rst; v.stF = stF; v.stD = stD; v.pcsrc = pcsrc; v.jump = jump;
    v.pcbr = pcbr; v.rdy = rdy; v.expAddr = expAddr; v.expInstr = expInstr;
    v.expP4 = expP4; v.expValid = expValid; v.expPend = expPend;
    vecs.push_back(v);
  endtask

  task automatic check(input int idx, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL v%0d %s got=%h expected=%h", idx, name, act, exp);
    end
  endtask

  initial begin
    // Fields: rst stF stD pcsrc jump pcbr rdy | addr instrD pcplus4D validD pending
    // Reset state.
    addVec(0, 0, 0, 0, 0, 32'h0, 1, 32'h0,  32'h0,          32'h0,  1'b0, 1'b0);
    // Streaming fetch: 0,4,8,C; instrD lags by one cycle.
    addVec(1, 0, 0, 0, 0, 32'h0, 1, 32'h4,  memWord(32'h0), 32'h4,  1'b1, 1'b0);
    addVec(1, 0, 0, 0, 0, 32'h0, 1, 32'h8,  memWord(32'h4), 32'h8,  1'b1, 1'b0);
    addVec(1, 0, 0, 0, 0, 32'h0, 1, 32'hC,  memWord(32'h8), 32'hC,  1'b1, 1'b0);
    // Taken branch for the instruction at 0x8 -> 0x40; one bubble, then 0x40.
    addVec(1, 0, 0, 1, 0, 32'h40, 1, 32'h40, 32'h0,           32'h0,  1'b0, 1'b0);
    addVec(1, 0, 0, 0, 0, 32'h0,  1, 32'h44, memWord(32'h40), 32'h44, 1'b1, 1'b0);
    addVec(1, 0, 0, 0, 0, 32'h0,  1, 32'h48, memWord(32'h44), 32'h48, 1'b1, 1'b0);
    addVec(1, 0, 0, 0, 0, 32'h0,  1, 32'h4C, memWord(32'h48), 32'h4C, 1'b1, 1'b0);
    // Full stall for three cycles at 0x4C; branch request ignored under stallD.
    addVec(1, 1, 1, 0, 0, 32'h0,  1, 32'h4C, memWord(32'h48), 32'h4C, 1'b1, 1'b0);
    addVec(1, 1, 1, 1, 0, 32'h80, 1, 32'h4C, memWord(32'h48), 32'h4C, 1'b1, 1'b0);
    addVec(1, 1, 1, 0, 0, 32'h0,  1, 32'h4C, memWord(32'h48), 32'h4C, 1'b1, 1'b0);
    // Release: next word is 0x4C, nothing lost or duplicated.
    addVec(1, 0, 0, 0, 0, 32'h0,  1, 32'h50, memWord(32'h4C), 32'h50, 1'b1, 1'b0);
    // Memory wait for two cycles at 0x50, then the word enters D once.
    addVec(1, 0, 0, 0, 0, 32'h0,  0, 32'h50, 32'h0,           32'h0,  1'b0, 1'b0);
    addVec(1, 0, 0, 0, 0, 32'h0,  0, 32'h50, 32'h0,           32'h0,  1'b0, 1'b0);
    addVec(1, 0, 0, 0, 0, 32'h0,  1, 32'h54, memWord(32'h50), 32'h54, 1'b1, 1'b0);
    // Branch to 0x100 to bring "j 0x40" into D with pcplus4D=0x104.
    addVec(1, 0, 0, 1, 0, 32'h100, 1, 32'h100, 32'h0,            32'h0,   1'b0, 1'b0);
    addVec(1, 0, 0, 0, 0, 32'h0,   1, 32'h104, memWord(32'h100), 32'h104, 1'b1, 1'b0);
    // Jump while stallF=1, stallD=0: parked, PC held, D flushed.
    addVec(1, 1, 0, 0, 1, 32'h0,   1, 32'h104, 32'h0,            32'h0,   1'b0, 1'b1);
    // stallF drops; jumpD left high but validD=0 so it is ignored. Parked
    // target applied, D still a bubble.
    addVec(1, 0, 0, 0, 1, 32'h0,   1, 32'h40,  32'h0,            32'h0,   1'b0, 1'b0);
    addVec(1, 0, 0, 0, 0, 32'h0,   1, 32'h44,  memWord(32'h40),  32'h44,  1'b1, 1'b0);
    addVec(1, 0, 0, 0, 0, 32'h0,   1, 32'h48,  memWord(32'h44),  32'h48,  1'b1, 1'b0);
    // Jump and branch together: jump target 0x100 beats pcbranchD=0x200.
    addVec(1, 0, 0, 1, 1, 32'h200, 1, 32'h100, 32'h0,            32'h0,   1'b0, 1'b0);
    addVec(1, 0, 0, 0, 0, 32'h0,   1, 32'h104, memWord(32'h100), 32'h104, 1'b1, 1'b0);
    // Park a redirect, then reset during the stall clears it.
    addVec(1, 1, 0, 0, 1, 32'h0,   1, 32'h104, 32'h0,            32'h0,   1'b0, 1'b1);
    addVec(0, 1, 0, 0, 0, 32'h0,   1, 32'h0,   32'h0,            32'h0,   1'b0, 1'b0);
    addVec(1, 0, 0, 0, 0, 32'h0,   1, 32'h4,   memWord(32'h0),   32'h4,   1'b1, 1'b0);
    // Branch to the top word; PC+4 wraps to 0.
    addVec(1, 0, 0, 1, 0, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 1'b0);
    addVec(1, 0, 0, 0, 0, 32'h0, 1, 32'h0, memWord(32'hFFFF_FFFC), 32'h0, 1'b1, 1'b0);
    addVec(1, 0, 0, 0, 0, 32'h0, 1, 32'h4, memWord(32'h0),         32'h4, 1'b1, 1'b0);
    // stallF alone: PC held, bubble into D; then resume.
    addVec(1, 1, 0, 0, 0, 32'h0, 1, 32'h4, 32'h0,                  32'h0, 1'b0, 1'b0);
    addVec(1, 0, 0, 0, 0, 32'h0, 1, 32'h8, memWord(32'h4),         32'h8, 1'b1, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      reset          = vecs[i].rst;
      stallF         = vecs[i].stF;
      stallD         = vecs[i].stD;
      pcsrcD         = vecs[i].pcsrc;
      jumpD          = vecs[i].jump;
      pcbranchD      = vecs[i].pcbr;
      bus.imem_ready = vecs[i].rdy;
      @(posedge clk);
      #1;
      check(i, "imem_addr",        bus.imem_addr,            vecs[i].expAddr);
      check(i, "instrD",           instrD,                   vecs[i].expInstr);
      check(i, "pcplus4D",         pcplus4D,                 vecs[i].expP4);
      check(i, "validD",           {31'b0, validD},          {31'b0, vecs[i].expValid});
      check(i, "redirect_pending", {31'b0, redirect_pending}, {31'b0, vecs[i].expPend});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
